// File: rtl/conv1x1_addr_ctrl_v2.sv
// Address and PE-control sequencer for 1x1 convolution: pixel -> filter group -> channel chunk.
// Optional perf counters (perf_cycles/perf_stalls) are enabled by defining CONV1X1_PERF_CNT_EN.
module conv1x1_addr_ctrl_v2 #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 11,
  parameter int PIX_W  = 16,
  parameter int NUM_PE = 4,
  parameter int LANES  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cal_start,
  input  logic              valid,
  input  logic [CNT_W-1:0]  weight_c,
  input  logic [CNT_W-1:0]  num_filter,
  input  logic [PIX_W-1:0]  num_pixel,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic [ADDR_W-1:0] addr_ifm,
  output logic [ADDR_W-1:0] addr_weight,
  output logic              addr_valid,
  output logic [NUM_PE-1:0] PE_reset,
  output logic [NUM_PE-1:0] PE_finish,
  output logic              busy,
  output logic              done
`ifdef CONV1X1_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W:0]    LP_LANES_C = (CNT_W+1)'(LANES);
  localparam logic [CNT_W:0]    LP_PE_C    = (CNT_W+1)'(NUM_PE);
  localparam logic [ADDR_W-1:0] LP_LANES_A = ADDR_W'(LANES);
  localparam logic [NUM_PE-1:0] LP_ONES    = {NUM_PE{1'b1}};

  state_t            r_state;
  logic              r_start_d;
  logic              r_armed;
  logic [CNT_W-1:0]  r_wc;
  logic [CNT_W-1:0]  r_nf;
  logic [PIX_W-1:0]  r_np;
  logic [CNT_W-1:0]  r_k;
  logic [CNT_W-1:0]  r_f;
  logic [PIX_W-1:0]  r_p;
  logic [ADDR_W-1:0] r_wgt_base;
  logic [ADDR_W-1:0] r_ifm_row;
  logic [ADDR_W-1:0] r_wgt_grp;

  logic              w_start;
  logic              w_degen;
  logic              w_last_chunk;
  logic              w_last_group;
  logic              w_last_pixel;
  logic [CNT_W:0]    w_k_sum;
  logic [CNT_W:0]    w_f_sum;
  logic [PIX_W:0]    w_p_sum;
  logic [ADDR_W-1:0] w_wc_ext;
  logic [ADDR_W-1:0] w_ifm_next_row;
  logic [ADDR_W-1:0] w_wgt_next_grp;

  // r_armed blocks a start from a cal_start level that was already high across reset.
  assign w_start        = (r_state == ST_IDLE) & cal_start & ~r_start_d & r_armed;
  assign w_degen        = (weight_c == {CNT_W{1'b0}}) | (num_filter == {CNT_W{1'b0}})
                        | (num_pixel == {PIX_W{1'b0}});
  assign w_k_sum        = {1'b0, r_k} + LP_LANES_C;
  assign w_f_sum        = {1'b0, r_f} + LP_PE_C;
  assign w_p_sum        = {1'b0, r_p} + {{PIX_W{1'b0}}, 1'b1};
  assign w_last_chunk   = (w_k_sum >= {1'b0, r_wc});
  assign w_last_group   = (w_f_sum >= {1'b0, r_nf});
  assign w_last_pixel   = (w_p_sum == {1'b0, r_np});
  assign w_wc_ext       = ADDR_W'(r_wc);
  assign w_ifm_next_row = r_ifm_row + w_wc_ext;
  assign w_wgt_next_grp = r_wgt_grp + w_wc_ext;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_start_d   <= 1'b0;
      r_armed     <= 1'b0;
      r_wc        <= {CNT_W{1'b0}};
      r_nf        <= {CNT_W{1'b0}};
      r_np        <= {PIX_W{1'b0}};
      r_k         <= {CNT_W{1'b0}};
      r_f         <= {CNT_W{1'b0}};
      r_p         <= {PIX_W{1'b0}};
      r_wgt_base  <= {ADDR_W{1'b0}};
      r_ifm_row   <= {ADDR_W{1'b0}};
      r_wgt_grp   <= {ADDR_W{1'b0}};
      addr_ifm    <= {ADDR_W{1'b0}};
      addr_weight <= {ADDR_W{1'b0}};
      addr_valid  <= 1'b0;
      PE_reset    <= {NUM_PE{1'b0}};
      PE_finish   <= {NUM_PE{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_start_d <= cal_start;
      if (!cal_start) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
      case (r_state)
        ST_IDLE: begin
          done      <= 1'b0;
          PE_finish <= {NUM_PE{1'b0}};
          if (w_start) begin
            r_wc       <= weight_c;
            r_nf       <= num_filter;
            r_np       <= num_pixel;
            r_wgt_base <= wgt_base;
            r_ifm_row  <= ifm_base;
            r_wgt_grp  <= wgt_base;
            r_k        <= {CNT_W{1'b0}};
            r_f        <= {CNT_W{1'b0}};
            r_p        <= {PIX_W{1'b0}};
            busy       <= 1'b1;
            if (w_degen) begin
              r_state    <= ST_FLUSH;
              addr_valid <= 1'b0;
              PE_reset   <= {NUM_PE{1'b0}};
              done       <= 1'b1;
            end else begin
              r_state     <= ST_FETCH;
              addr_valid  <= 1'b1;
              PE_reset    <= LP_ONES;
              addr_ifm    <= ifm_base;
              addr_weight <= wgt_base;
            end
          end else begin
            busy       <= 1'b0;
            addr_valid <= 1'b0;
            PE_reset   <= {NUM_PE{1'b0}};
          end
        end
        ST_FETCH: begin
          if (!cal_start) begin
            r_state     <= ST_IDLE;
            r_k         <= {CNT_W{1'b0}};
            r_f         <= {CNT_W{1'b0}};
            r_p         <= {PIX_W{1'b0}};
            addr_ifm    <= {ADDR_W{1'b0}};
            addr_weight <= {ADDR_W{1'b0}};
            addr_valid  <= 1'b0;
            PE_reset    <= {NUM_PE{1'b0}};
            PE_finish   <= {NUM_PE{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
          end else if (valid) begin
            if (!w_last_chunk) begin
              r_k         <= w_k_sum[CNT_W-1:0];
              addr_ifm    <= addr_ifm + LP_LANES_A;
              addr_weight <= addr_weight + LP_LANES_A;
              PE_reset    <= {NUM_PE{1'b0}};
              PE_finish   <= {NUM_PE{1'b0}};
            end else begin
              r_k       <= {CNT_W{1'b0}};
              PE_finish <= LP_ONES;
              if (!w_last_group) begin
                r_f         <= w_f_sum[CNT_W-1:0];
                r_wgt_grp   <= w_wgt_next_grp;
                addr_weight <= w_wgt_next_grp;
                addr_ifm    <= r_ifm_row;
                PE_reset    <= LP_ONES;
              end else begin
                r_f         <= {CNT_W{1'b0}};
                r_p         <= w_p_sum[PIX_W-1:0];
                r_ifm_row   <= w_ifm_next_row;
                r_wgt_grp   <= r_wgt_base;
                addr_weight <= r_wgt_base;
                addr_ifm    <= w_ifm_next_row;
                if (w_last_pixel) begin
                  r_state    <= ST_FLUSH;
                  addr_valid <= 1'b0;
                  PE_reset   <= {NUM_PE{1'b0}};
                  done       <= 1'b1;
                end else begin
                  PE_reset <= LP_ONES;
                end
              end
            end
          end else begin
            // Stall: everything holds, but a finish strobe must not stretch.
            PE_finish <= {NUM_PE{1'b0}};
          end
        end
        ST_FLUSH: begin
          r_state    <= ST_IDLE;
          addr_valid <= 1'b0;
          PE_reset   <= {NUM_PE{1'b0}};
          PE_finish  <= {NUM_PE{1'b0}};
          busy       <= 1'b0;
          done       <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          addr_valid <= 1'b0;
          PE_reset   <= {NUM_PE{1'b0}};
          PE_finish  <= {NUM_PE{1'b0}};
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV1X1_PERF_CNT_EN
  // Saturating busy-cycle and stall counters, cleared on job start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= 32'd0;
      perf_stalls <= 32'd0;
    end else if (w_start) begin
      perf_cycles <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end else begin
        perf_cycles <= perf_cycles;
      end
      if ((r_state == ST_FETCH) && !valid && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end else begin
        perf_stalls <= perf_stalls;
      end
    end
  end
`endif

endmodule
